d_e_pipe_reg: RTL and testbench

//   D->E pipeline register of the 5-stage MIPS core. Sits directly downstream of the D-stage
//   set-word unit (lui / jal-link value) and the GRF read ports; latches the decoded bundle into E.

---
 rtl/d_e_pipe_reg_pkg.sv | 36 +++
 rtl/d_e_pipe_reg_if.sv | 57 +++++
 rtl/d_e_pipe_reg.sv | 134 +++++++++++++
 tb/tb_d_e_pipe_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/d_e_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// d_e_pipe_reg_pkg
//   Shared constants and helpers for the D->E pipeline register.
//   - DW_DEF / BCNT_W_DEF : default datapath and bubble-counter widths
//   - TNEW_W              : width of the Tnew (cycles-until-result) field
//   - NOP_INSTR           : instruction word inserted for a bubble
//   - pipe_act_e          : per-edge action selected for the E-stage bundle
//   - tnew_step()         : advances Tnew by one stage without wrapping
// -----------------------------------------------------------------------------
package d_e_pipe_reg_pkg;

    localparam int DW_DEF     = 32;
    localparam int BCNT_W_DEF = 32;
    localparam int TNEW_W     = 2;

    // sll $0,$0,0 encodes as all zeros, so a bubble is simply a zero word
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_LOAD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } pipe_act_e;

    // One stage closer to the result; a result already final stays final
    function automatic logic [TNEW_W-1:0] tnew_step(input logic [TNEW_W-1:0] t);
        logic [TNEW_W-1:0] res;
        if (t == {TNEW_W{1'b0}}) begin
            res = {TNEW_W{1'b0}};
        end else begin
            res = t - {{(TNEW_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/d_e_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// d_e_pipe_reg_if
//   Bundle between the D stage (master) and the D->E pipeline register (slave).
//   master drives : en, clr, D_* decoded bundle
//   master reads  : E_* registered bundle, E_FwdValid/E_FwdData, bubble_cnt
//   slave         : mirror image of master
// -----------------------------------------------------------------------------
interface d_e_pipe_reg_if
    import d_e_pipe_reg_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int BCNT_W = BCNT_W_DEF
);

    logic              en;
    logic              clr;

    logic [DW-1:0]     D_instr;
    logic [DW-1:0]     D_PC;
    logic [DW-1:0]     D_RD1;
    logic [DW-1:0]     D_RD2;
    logic [DW-1:0]     D_imm32;
    logic [DW-1:0]     D_SetWordResult;
    logic [4:0]        D_A3;
    logic              D_RegWrite;
    logic [TNEW_W-1:0] D_Tnew;

    logic [DW-1:0]     E_instr;
    logic [DW-1:0]     E_PC;
    logic [DW-1:0]     E_RD1;
    logic [DW-1:0]     E_RD2;
    logic [DW-1:0]     E_imm32;
    logic [DW-1:0]     E_SetWordResult;
    logic [4:0]        E_A3;
    logic              E_RegWrite;
    logic [TNEW_W-1:0] E_Tnew;
    logic              E_FwdValid;
    logic [DW-1:0]     E_FwdData;
    logic [BCNT_W-1:0] bubble_cnt;

    modport master (
        output en, clr,
        output D_instr, D_PC, D_RD1, D_RD2, D_imm32, D_SetWordResult,
        output D_A3, D_RegWrite, D_Tnew,
        input  E_instr, E_PC, E_RD1, E_RD2, E_imm32, E_SetWordResult,
        input  E_A3, E_RegWrite, E_Tnew, E_FwdValid, E_FwdData, bubble_cnt
    );

    modport slave (
        input  en, clr,
        input  D_instr, D_PC, D_RD1, D_RD2, D_imm32, D_SetWordResult,
        input  D_A3, D_RegWrite, D_Tnew,
        output E_instr, E_PC, E_RD1, E_RD2, E_imm32, E_SetWordResult,
        output E_A3, E_RegWrite, E_Tnew, E_FwdValid, E_FwdData, bubble_cnt
    );

endinterface

// File: rtl/d_e_pipe_reg.sv
// -----------------------------------------------------------------------------
// d_e_pipe_reg
//   D->E pipeline register of the 5-stage MIPS core. Latches the decoded D
//   bundle into E, inserts bubbles on clr, holds on !en, forwards results that
//   are already final in E (set-word results such as lui / jal link value) and
//   counts inserted bubbles (saturating).
//   Ports:
//     clk   : core clock, all state on rising edge
//     reset : asynchronous, active-high, clears all state
//     bus   : d_e_pipe_reg_if.slave (en, clr, D_* in; E_*, fwd, bubble_cnt out)
//   Per-edge priority: reset > clr > !en > load.
//   No combinational path from any D_* input to any output.
// -----------------------------------------------------------------------------
module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int BCNT_W = BCNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    d_e_pipe_reg_if.slave  bus
);

    pipe_act_e         w_act;

    logic [DW-1:0]     r_instr;
    logic [DW-1:0]     r_pc;
    logic [DW-1:0]     r_rd1;
    logic [DW-1:0]     r_rd2;
    logic [DW-1:0]     r_imm32;
    logic [DW-1:0]     r_setword;
    logic [4:0]        r_a3;
    logic              r_regwrite;
    logic [TNEW_W-1:0] r_tnew;
    logic [BCNT_W-1:0] r_bubble_cnt;

    logic              w_fwd_valid;
    logic [DW-1:0]     w_fwd_data;

    // Decode the per-edge action; clr wins over a stall so a flush is never lost
    always_comb begin
        w_act = ACT_HOLD;
        if (bus.clr) begin
            w_act = ACT_BUBBLE;
        end else if (bus.en) begin
            w_act = ACT_LOAD;
        end else begin
            w_act = ACT_HOLD;
        end
    end

    // E-stage bundle register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr    <= {DW{1'b0}};
            r_pc       <= {DW{1'b0}};
            r_rd1      <= {DW{1'b0}};
            r_rd2      <= {DW{1'b0}};
            r_imm32    <= {DW{1'b0}};
            r_setword  <= {DW{1'b0}};
            r_a3       <= 5'd0;
            r_regwrite <= 1'b0;
            r_tnew     <= {TNEW_W{1'b0}};
        end else begin
            case (w_act)
                ACT_LOAD: begin
                    r_instr    <= bus.D_instr;
                    r_pc       <= bus.D_PC;
                    r_rd1      <= bus.D_RD1;
                    r_rd2      <= bus.D_RD2;
                    r_imm32    <= bus.D_imm32;
                    r_setword  <= bus.D_SetWordResult;
                    r_a3       <= bus.D_A3;
                    r_regwrite <= bus.D_RegWrite;
                    r_tnew     <= tnew_step(bus.D_Tnew);
                end
                ACT_BUBBLE: begin
                    // PC still tracks D so the bubble reports a sensible address later
                    r_instr    <= NOP_INSTR[DW-1:0];
                    r_pc       <= bus.D_PC;
                    r_rd1      <= {DW{1'b0}};
                    r_rd2      <= {DW{1'b0}};
                    r_imm32    <= {DW{1'b0}};
                    r_setword  <= {DW{1'b0}};
                    r_a3       <= 5'd0;
                    r_regwrite <= 1'b0;
                    r_tnew     <= {TNEW_W{1'b0}};
                end
                default: begin
                    // stall: hold everything, Tnew is not advanced either
                    r_instr    <= r_instr;
                    r_pc       <= r_pc;
                    r_rd1      <= r_rd1;
                    r_rd2      <= r_rd2;
                    r_imm32    <= r_imm32;
                    r_setword  <= r_setword;
                    r_a3       <= r_a3;
                    r_regwrite <= r_regwrite;
                    r_tnew     <= r_tnew;
                end
            endcase
        end
    end

    // Bubble counter, saturates at all-ones instead of wrapping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= {BCNT_W{1'b0}};
        end else if ((w_act == ACT_BUBBLE) && (r_bubble_cnt != {BCNT_W{1'b1}})) begin
            r_bubble_cnt <= r_bubble_cnt + {{(BCNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
        end
    end

    // Writes to $0 are never forwarded; data is gated so the forward mux never sees X
    assign w_fwd_valid = r_regwrite & (r_a3 != 5'd0) & (r_tnew == {TNEW_W{1'b0}});
    assign w_fwd_data  = w_fwd_valid ? r_setword : {DW{1'b0}};

    assign bus.E_instr         = r_instr;
    assign bus.E_PC            = r_pc;
    assign bus.E_RD1           = r_rd1;
    assign bus.E_RD2           = r_rd2;
    assign bus.E_imm32         = r_imm32;
    assign bus.E_SetWordResult = r_setword;
    assign bus.E_A3            = r_a3;
    assign bus.E_RegWrite      = r_regwrite;
    assign bus.E_Tnew          = r_tnew;
    assign bus.E_FwdValid      = w_fwd_valid;
    assign bus.E_FwdData       = w_fwd_data;
    assign bus.bubble_cnt      = r_bubble_cnt;

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_d_e_pipe_reg
//   Directed bench for d_e_pipe_reg. u_dut uses the default widths; u_sat has a
//   2-bit bubble counter so counter saturation is reachable in a few cycles.
// -----------------------------------------------------------------------------
module tb_d_e_pipe_reg;
    import d_e_pipe_reg_pkg::*;

    logic clk;
    logic reset;

    int n_checks;
    int n_fail;

    d_e_pipe_reg_if #(.DW(32), .BCNT_W(32)) bus ();
    d_e_pipe_reg_if #(.DW(32), .BCNT_W(2))  bus_s ();

    d_e_pipe_reg #(.DW(32), .BCNT_W(32)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    d_e_pipe_reg #(.DW(32), .BCNT_W(2)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one active edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] instr, input logic [31:0] pc,
                           input logic [31:0] sw, input logic [4:0] a3,
                           input logic rw, input logic [1:0] tnew);
        bus.D_instr         = instr;
        bus.D_PC            = pc;
        bus.D_RD1           = instr ^ 32'h1111_1111;
        bus.D_RD2           = instr ^ 32'h2222_2222;
        bus.D_imm32         = pc ^ 32'h0000_FFFF;
        bus.D_SetWordResult = sw;
        bus.D_A3            = a3;
        bus.D_RegWrite      = rw;
        bus.D_Tnew          = tnew;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.E_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want %h", bus.E_instr, 32'h0); end
        n_checks++; if (bus.E_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.E_PC, 32'h0); end
        n_checks++; if (bus.E_RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_rw got %b want 0", bus.E_RegWrite); end
        n_checks++; if (bus.E_FwdValid !== 1'b0) begin n_fail++; $display("FAIL reset_fwdv got %b want 0", bus.E_FwdValid); end
        n_checks++; if (bus.E_FwdData !== 32'h0) begin n_fail++; $display("FAIL reset_fwdd got %h want %h", bus.E_FwdData, 32'h0); end
        n_checks++; if (bus.bubble_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_bcnt got %0d want 0", bus.bubble_cnt); end
        reset = 1'b0;
    endtask

    task automatic test_lui();
        bus.en  = 1'b1;
        bus.clr = 1'b0;
        drive_d(32'h3C08_1234, 32'h0000_3000, 32'h1234_0000, 5'd8, 1'b1, 2'd0);
        tick();
        n_checks++; if (bus.E_FwdValid !== 1'b1) begin n_fail++; $display("FAIL lui_fwdv got %b want 1", bus.E_FwdValid); end
        n_checks++; if (bus.E_FwdData !== 32'h1234_0000) begin n_fail++; $display("FAIL lui_fwdd got %h want %h", bus.E_FwdData, 32'h1234_0000); end
        n_checks++; if (bus.E_A3 !== 5'd8) begin n_fail++; $display("FAIL lui_a3 got %0d want 8", bus.E_A3); end
        n_checks++; if (bus.E_instr !== 32'h3C08_1234) begin n_fail++; $display("FAIL lui_instr got %h want %h", bus.E_instr, 32'h3C08_1234); end
        n_checks++; if (bus.E_RD1 !== 32'h2D19_0325) begin n_fail++; $display("FAIL lui_rd1 got %h want %h", bus.E_RD1, 32'h2D19_0325); end
        n_checks++; if (bus.E_imm32 !== 32'h0000_CFFF) begin n_fail++; $display("FAIL lui_imm got %h want %h", bus.E_imm32, 32'h0000_CFFF); end
    endtask

    task automatic test_jal_hold();
        bus.en  = 1'b1;
        drive_d(32'h0C00_0C10, 32'h0000_3000, 32'h0000_3008, 5'd31, 1'b1, 2'd0);
        tick();
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_d(32'hABCD_0000 + i, 32'h0000_4000 + 4 * i, 32'h5555_0000 + i, 5'd3, 1'b0, 2'd2);
            tick();
            n_checks++; if (bus.E_SetWordResult !== 32'h0000_3008) begin n_fail++; $display("FAIL hold_sw got %h want %h", bus.E_SetWordResult, 32'h0000_3008); end
            n_checks++; if (bus.E_A3 !== 5'd31) begin n_fail++; $display("FAIL hold_a3 got %0d want 31", bus.E_A3); end
            n_checks++; if (bus.E_Tnew !== 2'd0) begin n_fail++; $display("FAIL hold_tnew got %0d want 0", bus.E_Tnew); end
            n_checks++; if (bus.E_PC !== 32'h0000_3000) begin n_fail++; $display("FAIL hold_pc got %h want %h", bus.E_PC, 32'h0000_3000); end
            n_checks++; if (bus.bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL hold_bcnt got %0d want 0", bus.bubble_cnt); end
        end
    endtask

    task automatic test_tnew();
        bus.en = 1'b1;
        drive_d(32'h0109_5021, 32'h0000_3004, 32'h0000_0000, 5'd10, 1'b1, 2'd1);
        tick();
        n_checks++; if (bus.E_Tnew !== 2'd0) begin n_fail++; $display("FAIL tnew1_e got %0d want 0", bus.E_Tnew); end
        n_checks++; if (bus.E_FwdValid !== 1'b1) begin n_fail++; $display("FAIL tnew1_fwdv got %b want 1", bus.E_FwdValid); end
        drive_d(32'h8D09_0004, 32'h0000_3008, 32'hDEAD_BEEF, 5'd9, 1'b1, 2'd2);
        tick();
        n_checks++; if (bus.E_Tnew !== 2'd1) begin n_fail++; $display("FAIL tnew2_e got %0d want 1", bus.E_Tnew); end
        n_checks++; if (bus.E_FwdValid !== 1'b0) begin n_fail++; $display("FAIL tnew2_fwdv got %b want 0", bus.E_FwdValid); end
        n_checks++; if (bus.E_FwdData !== 32'h0) begin n_fail++; $display("FAIL tnew2_fwdd got %h want %h", bus.E_FwdData, 32'h0); end
        drive_d(32'h8D09_0008, 32'h0000_300C, 32'h0000_0000, 5'd9, 1'b1, 2'd3);
        tick();
        n_checks++; if (bus.E_Tnew !== 2'd2) begin n_fail++; $display("FAIL tnew3_e got %0d want 2", bus.E_Tnew); end
        drive_d(32'hAD09_0000, 32'h0000_3010, 32'h7777_0000, 5'd9, 1'b0, 2'd0);
        tick();
        n_checks++; if (bus.E_FwdValid !== 1'b0) begin n_fail++; $display("FAIL norw_fwdv got %b want 0", bus.E_FwdValid); end
    endtask

    task automatic test_bubble();
        bus.en  = 1'b0;
        bus.clr = 1'b1;
        drive_d(32'h3C09_00FF, 32'h0000_3010, 32'h00FF_0000, 5'd9, 1'b1, 2'd1);
        tick();
        n_checks++; if (bus.E_instr !== 32'h0) begin n_fail++; $display("FAIL bub_instr got %h want %h", bus.E_instr, 32'h0); end
        n_checks++; if (bus.E_RegWrite !== 1'b0) begin n_fail++; $display("FAIL bub_rw got %b want 0", bus.E_RegWrite); end
        n_checks++; if (bus.E_PC !== 32'h0000_3010) begin n_fail++; $display("FAIL bub_pc got %h want %h", bus.E_PC, 32'h0000_3010); end
        n_checks++; if (bus.E_RD2 !== 32'h0) begin n_fail++; $display("FAIL bub_rd2 got %h want %h", bus.E_RD2, 32'h0); end
        n_checks++; if (bus.E_SetWordResult !== 32'h0) begin n_fail++; $display("FAIL bub_sw got %h want %h", bus.E_SetWordResult, 32'h0); end
        n_checks++; if (bus.E_A3 !== 5'd0) begin n_fail++; $display("FAIL bub_a3 got %0d want 0", bus.E_A3); end
        n_checks++; if (bus.bubble_cnt !== 32'd1) begin n_fail++; $display("FAIL bub_bcnt1 got %0d want 1", bus.bubble_cnt); end
        bus.en = 1'b1;
        drive_d(32'h3C0A_00EE, 32'h0000_3014, 32'h00EE_0000, 5'd10, 1'b1, 2'd0);
        tick();
        n_checks++; if (bus.E_instr !== 32'h0) begin n_fail++; $display("FAIL bub_en_instr got %h want %h", bus.E_instr, 32'h0); end
        n_checks++; if (bus.E_PC !== 32'h0000_3014) begin n_fail++; $display("FAIL bub_en_pc got %h want %h", bus.E_PC, 32'h0000_3014); end
        n_checks++; if (bus.bubble_cnt !== 32'd2) begin n_fail++; $display("FAIL bub_bcnt2 got %0d want 2", bus.bubble_cnt); end
        bus.clr = 1'b0;
    endtask

    task automatic test_zero_dest();
        bus.en = 1'b1;
        drive_d(32'h3C00_5678, 32'h0000_3018, 32'h5678_0000, 5'd0, 1'b1, 2'd0);
        tick();
        n_checks++; if (bus.E_FwdValid !== 1'b0) begin n_fail++; $display("FAIL zero_fwdv got %b want 0", bus.E_FwdValid); end
        n_checks++; if (bus.E_FwdData !== 32'h0) begin n_fail++; $display("FAIL zero_fwdd got %h want %h", bus.E_FwdData, 32'h0); end
        n_checks++; if (bus.E_SetWordResult !== 32'h5678_0000) begin n_fail++; $display("FAIL zero_sw got %h want %h", bus.E_SetWordResult, 32'h5678_0000); end
        n_checks++; if (bus.bubble_cnt !== 32'd2) begin n_fail++; $display("FAIL zero_bcnt got %0d want 2", bus.bubble_cnt); end
    endtask

    task automatic test_async_reset();
        bus.en = 1'b1;
        drive_d(32'h3C0B_4321, 32'h0000_301C, 32'h4321_0000, 5'd11, 1'b1, 2'd0);
        tick();
        bus.en = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.E_instr !== 32'h0) begin n_fail++; $display("FAIL areset_instr got %h want %h", bus.E_instr, 32'h0); end
        n_checks++; if (bus.E_SetWordResult !== 32'h0) begin n_fail++; $display("FAIL areset_sw got %h want %h", bus.E_SetWordResult, 32'h0); end
        n_checks++; if (bus.E_PC !== 32'h0) begin n_fail++; $display("FAIL areset_pc got %h want %h", bus.E_PC, 32'h0); end
        n_checks++; if (bus.E_FwdValid !== 1'b0) begin n_fail++; $display("FAIL areset_fwdv got %b want 0", bus.E_FwdValid); end
        n_checks++; if (bus.bubble_cnt !== 32'd0) begin n_fail++; $display("FAIL areset_bcnt got %0d want 0", bus.bubble_cnt); end
        bus.en = 1'b1;
        tick();
        n_checks++; if (bus.E_instr !== 32'h0) begin n_fail++; $display("FAIL areset_held got %h want %h", bus.E_instr, 32'h0); end
        reset = 1'b0;
        drive_d(32'h3C0C_0042, 32'h0000_3020, 32'h0042_0000, 5'd12, 1'b1, 2'd0);
        tick();
        n_checks++; if (bus.E_FwdData !== 32'h0042_0000) begin n_fail++; $display("FAIL first_load got %h want %h", bus.E_FwdData, 32'h0042_0000); end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [4];
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3;
        bus_s.clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (bus_s.bubble_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_cnt%0d got %0d want %0d", i, bus_s.bubble_cnt, exp_cnt[i]); end
        end
        bus_s.clr = 1'b0;
        tick();
        n_checks++; if (bus_s.bubble_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold got %0d want 3", bus_s.bubble_cnt); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.clr  = 1'b0;
        drive_d(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
        bus_s.en              = 1'b0;
        bus_s.clr             = 1'b0;
        bus_s.D_instr         = 32'h0;
        bus_s.D_PC            = 32'h0;
        bus_s.D_RD1           = 32'h0;
        bus_s.D_RD2           = 32'h0;
        bus_s.D_imm32         = 32'h0;
        bus_s.D_SetWordResult = 32'h0;
        bus_s.D_A3            = 5'd0;
        bus_s.D_RegWrite      = 1'b0;
        bus_s.D_Tnew          = 2'd0;

        test_reset();
        test_lui();
        test_jal_hold();
        test_tnew();
        test_bubble();
        test_zero_dest();
        test_async_reset();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
